// File: rtl/spi_note_sender_pkg.sv
// spi_note_sender_pkg: shared constants, FSM states and frame byte selection for the SPI note sender.
package spi_note_sender_pkg;
    localparam logic [7:0] NOTEON  = 8'h90;
    localparam logic [7:0] NOTEOFF = 8'h80;
    localparam int NOTE_ON_BYTES  = 4;
    localparam int NOTE_OFF_BYTES = 2;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SCLK_HI, S_SCLK_LO, S_GAP, S_TAIL} state_t;
    function automatic logic [7:0] frame_byte(input logic [7:0] status, input logic [1:0] idx,
                                              input logic [7:0] voice, input logic [6:0] note,
                                              input logic [6:0] vel);
        return idx == 2'd0 ? status : idx == 2'd1 ? voice : idx == 2'd2 ? {1'b0, note} : {1'b0, vel};
    endfunction
endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: CPOL0/CPHA0 byte serializer, MSB first; one setup phase, then 8 high/low SCLK phases.
module spi_byte_shifter
    import spi_note_sender_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_done
);
    localparam int DW = $clog2(CLK_DIV);
    state_t r_state, w_next;
    logic [DW-1:0] r_div;
    logic [2:0] r_bit;
    logic [7:0] r_sh;
    logic r_fin;
    logic w_div_end;
    assign w_div_end = r_div == DW'(CLK_DIV - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= S_IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_SETUP;
            S_SETUP, S_SCLK_LO:
                if (w_div_end) w_next = (r_state == S_SCLK_LO && r_fin) ? S_IDLE : S_SCLK_HI;
            S_SCLK_HI: if (w_div_end) w_next = S_SCLK_LO;
            default:   w_next = S_IDLE;
        endcase
    end
    always_comb begin
        o_sclk = r_state == S_SCLK_HI;
        o_mosi = r_sh[7];
        o_done = r_state == S_SCLK_LO && w_div_end && r_fin;
    end
    // r_fin marks the trailing low phase after bit 0, where mosi must hold instead of shifting
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_div <= '0;
            r_bit <= '0;
            r_sh  <= '0;
            r_fin <= 1'b0;
        end else begin
            r_div <= (r_state == S_IDLE || w_div_end) ? '0 : r_div + 1'b1;
            if (r_state == S_IDLE && i_start) begin
                r_sh  <= i_byte;
                r_bit <= 3'd7;
                r_fin <= 1'b0;
            end else if (r_state == S_SCLK_HI && w_div_end) begin
                r_fin <= r_bit == 3'd0;
                if (r_bit != 3'd0) begin
                    r_sh  <= r_sh << 1;
                    r_bit <= r_bit - 1'b1;
                end
            end
        end
endmodule

// File: rtl/spi_note_sender.sv
// spi_note_sender: accepts note events and sends them as 4-byte note-on / 2-byte note-off SPI frames.
module spi_note_sender
    import spi_note_sender_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter int         GAP_CYCLES = 8,
    parameter logic [7:0] NOTEON     = spi_note_sender_pkg::NOTEON,
    parameter logic [7:0] NOTEOFF    = spi_note_sender_pkg::NOTEOFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       tx_note_status,
    input  logic [7:0] tx_voice_index,
    input  logic [6:0] tx_midi_note,
    input  logic [6:0] tx_velocity,
    output logic       SPI_sclk,
    output logic       SPI_mosi,
    output logic       SPI_cs_n,
    output logic       frame_done
);
    localparam int CW = $clog2((GAP_CYCLES > CLK_DIV ? GAP_CYCLES : CLK_DIV) + 1);
    state_t r_state, w_next;
    logic r_armed, r_on, r_done;
    logic [7:0] r_voice;
    logic [6:0] r_note, r_vel;
    logic [1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic w_accept, w_gap_end, w_tail_end, w_last, w_start, w_byte_done, w_mosi;
    logic [7:0] w_byte;
    assign w_accept   = tx_valid & tx_ready;
    assign w_gap_end  = r_state == S_GAP && r_cnt == CW'(GAP_CYCLES - 1);
    assign w_tail_end = r_state == S_TAIL && r_cnt == CW'(CLK_DIV - 1);
    assign w_last     = r_idx == (r_on ? 2'(NOTE_ON_BYTES - 1) : 2'(NOTE_OFF_BYTES - 1));
    assign w_start    = w_accept | w_gap_end;
    // byte 0 comes straight from the inputs so mosi is valid in the first SETUP cycle
    assign w_byte = w_accept
        ? (tx_note_status ? NOTEON : NOTEOFF)
        : frame_byte(r_on ? NOTEON : NOTEOFF, r_idx + 2'd1, r_voice, r_note, r_vel);
    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_byte  (w_byte),
        .o_sclk  (SPI_sclk),
        .o_mosi  (w_mosi),
        .o_done  (w_byte_done)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= S_IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SETUP;
            S_SETUP: if (w_byte_done) w_next = w_last ? S_TAIL : S_GAP;
            S_GAP:   if (w_gap_end) w_next = S_SETUP;
            S_TAIL:  if (w_tail_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    always_comb begin
        tx_ready   = r_state == S_IDLE && r_armed;
        SPI_cs_n   = r_state == S_IDLE;
        SPI_mosi   = r_state != S_IDLE && w_mosi;
        frame_done = r_done;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_armed <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_on    <= 1'b0;
            r_voice <= '0;
            r_note  <= '0;
            r_vel   <= '0;
        end else begin
            r_armed <= 1'b1;
            r_done  <= w_tail_end;
            r_cnt   <= ((r_state == S_GAP && !w_gap_end) || (r_state == S_TAIL && !w_tail_end))
                       ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_idx   <= '0;
                r_on    <= tx_note_status;
                r_voice <= tx_voice_index;
                r_note  <= tx_midi_note;
                r_vel   <= tx_velocity;
            end else if (w_gap_end) r_idx <= r_idx + 1'b1;
        end
endmodule

// File: tb/tb_spi_note_sender.sv
// tb_spi_note_sender: SPI slave/receiver model with byte and frame scoreboards, plus a fast-divider timing monitor.
module tb_spi_note_sender;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_valid = 1'b0, f_valid = 1'b0;
    logic tx_note_status = 1'b0;
    logic [7:0] tx_voice_index = '0;
    logic [6:0] tx_midi_note = '0, tx_velocity = '0;
    logic tx_ready, SPI_sclk, SPI_mosi, SPI_cs_n, frame_done;
    logic f_ready, f_sclk, f_mosi, f_cs_n, f_done;
    int n_cmp = 0, n_err = 0;
    logic [7:0] exp_b[$];
    logic [22:0] exp_f[$];
    int edges = 0, dones = 0, f_edges = 0, f_dones = 0;
    always #5 clk = ~clk;

    spi_note_sender u_dut (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_note_status(tx_note_status), .tx_voice_index(tx_voice_index),
        .tx_midi_note(tx_midi_note), .tx_velocity(tx_velocity),
        .SPI_sclk(SPI_sclk), .SPI_mosi(SPI_mosi), .SPI_cs_n(SPI_cs_n), .frame_done(frame_done)
    );
    spi_note_sender #(.CLK_DIV(2), .GAP_CYCLES(1)) u_fast (
        .clk(clk), .reset(reset), .tx_valid(f_valid), .tx_ready(f_ready),
        .tx_note_status(tx_note_status), .tx_voice_index(tx_voice_index),
        .tx_midi_note(tx_midi_note), .tx_velocity(tx_velocity),
        .SPI_sclk(f_sclk), .SPI_mosi(f_mosi), .SPI_cs_n(f_cs_n), .frame_done(f_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s: timed out", tag);
    endtask

    // receiver model: bytes on rising SCLK, frames decoded when cs_n returns high
    initial begin
        logic ps = 1'b0, pcs = 1'b1, pdone = 1'b0, pvalid = 1'b0;
        logic [7:0] sh = '0;
        logic [7:0] fb[4];
        int nb = 0, nf = 0;
        forever begin
            @(negedge clk);
            if (SPI_sclk && !ps) begin
                sh = {sh[6:0], SPI_mosi};
                nb++;
                edges++;
                if (nb == 8) begin
                    nb = 0;
                    if (nf < 4) fb[nf] = sh;
                    nf++;
                    if (exp_b.size() == 0) chk("unexpected_byte", {24'd0, sh}, 32'hFFFF_FFFF);
                    else chk("byte", {24'd0, sh}, {24'd0, exp_b.pop_front()});
                end
            end
            if (!SPI_cs_n) chk("ready_low_in_frame", {31'd0, tx_ready}, 32'd0);
            if (pdone && pvalid) chk("b2b_restart", {31'd0, SPI_cs_n}, 32'd0);
            if (SPI_cs_n && !pcs) begin
                if ((nf == 4 && fb[0] == 8'h90) || (nf == 2 && fb[0] == 8'h80)) begin
                    if (exp_f.size() == 0) chk("unexpected_frame", 32'd0, 32'd1);
                    else chk("rx_frame",
                             {9'd0, fb[0] == 8'h90, fb[1], nf == 4 ? fb[2][6:0] : 7'd0,
                              nf == 4 ? fb[3][6:0] : 7'd0},
                             {9'd0, exp_f.pop_front()});
                end
            end
            if (SPI_cs_n) begin
                nb = 0;
                nf = 0;
            end
            if (frame_done) dones++;
            pdone = frame_done;
            pvalid = tx_valid;
            ps = SPI_sclk;
            pcs = SPI_cs_n;
        end
    end

    // fast instance: phase lengths, inter-byte low span and mosi stability around SCLK high
    initial begin
        logic ps = 1'b0, pm = 1'b0, seen_fall = 1'b0;
        int hi = 0, lo = 0, nb = 0;
        forever begin
            @(negedge clk);
            if (f_sclk) begin
                chk("mosi_stable", {31'd0, f_mosi}, {31'd0, pm});
                if (!ps) begin
                    f_edges++;
                    if (seen_fall) chk("low_span", lo, nb == 0 ? 5 : 2);
                    nb = (nb + 1) % 8;
                    hi = 0;
                end
                hi++;
            end else begin
                if (ps) begin
                    chk("hi_phase", hi, 2);
                    seen_fall = 1'b1;
                    lo = 1;
                end else lo++;
            end
            if (f_cs_n) begin
                seen_fall = 1'b0;
                nb = 0;
            end
            if (f_done) f_dones++;
            ps = f_sclk;
            pm = f_mosi;
        end
    end

    task automatic push(input logic on, input logic [7:0] v, input logic [6:0] n, input logic [6:0] vel);
        exp_b.push_back(on ? 8'h90 : 8'h80);
        exp_b.push_back(v);
        if (on) begin
            exp_b.push_back({1'b0, n});
            exp_b.push_back({1'b0, vel});
        end
        exp_f.push_back({on, v, on ? n : 7'd0, on ? vel : 7'd0});
    endtask

    task automatic offer(input logic on, input logic [7:0] v, input logic [6:0] n, input logic [6:0] vel);
        int k = 0;
        tx_note_status = on;
        tx_voice_index = v;
        tx_midi_note = n;
        tx_velocity = vel;
        tx_valid = 1'b1;
        push(on, v, n, vel);
        while (!tx_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready) timeout("accept");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dones(input int target);
        int k = 0;
        while (dones < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (dones < target) timeout("frame_done");
    endtask

    initial begin
        int e0, k;
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {27'd0, tx_ready, SPI_sclk, SPI_mosi, SPI_cs_n, frame_done}, 32'b00010);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, tx_ready}, 32'd1);

        // note-on voice 3, note 60, velocity 100
        e0 = edges;
        offer(1'b1, 8'd3, 7'd60, 7'd100);
        tx_valid = 1'b0;
        tx_voice_index = 8'hEE;
        wait_dones(1);
        chk("noteon_edges", edges - e0, 32);
        chk("noteon_dones", dones, 1);
        @(negedge clk);
        chk("idle_after_noteon", {30'd0, SPI_cs_n, tx_ready}, 32'b11);

        // note-off voice 7; note/velocity inputs must be ignored
        e0 = edges;
        offer(1'b0, 8'd7, 7'd77, 7'd11);
        tx_valid = 1'b0;
        wait_dones(2);
        chk("noteoff_edges", edges - e0, 16);
        @(negedge clk);
        chk("noteoff_dones", dones, 2);

        // reset asserted while byte 2 of a note-on is being shifted
        offer(1'b1, 8'd2, 7'd40, 7'd50);
        tx_valid = 1'b0;
        k = 0;
        while (exp_b.size() > 2 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (exp_b.size() > 2) timeout("reach_byte2");
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("abort_outputs", {29'd0, SPI_cs_n, SPI_sclk, SPI_mosi}, 32'b100);
        exp_b.delete();
        exp_f.delete();
        @(negedge clk);
        chk("ready_in_reset", {31'd0, tx_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", {31'd0, tx_ready}, 32'd1);
        e0 = edges;
        repeat (150) @(negedge clk);
        chk("no_edges_after_abort", edges - e0, 0);
        chk("cs_high_after_abort", {31'd0, SPI_cs_n}, 32'd1);
        chk("dones_after_abort", dones, 2);

        // fast divider timing on the second instance
        tx_note_status = 1'b1;
        tx_voice_index = 8'hA5;
        tx_midi_note = 7'h55;
        tx_velocity = 7'h2A;
        f_valid = 1'b1;
        k = 0;
        while (!f_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 f_valid = 1'b0;
        k = 0;
        while (f_dones < 1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (f_dones < 1) timeout("fast_done");
        chk("fast_edges", f_edges, 32);

        // back-to-back with tx_valid held; fields change while frames are in flight
        e0 = edges;
        offer(1'b1, 8'd5, 7'd64, 7'd90);
        offer(1'b0, 8'd9, 7'd77, 7'd11);
        offer(1'b1, 8'd1, 7'd70, 7'd33);
        tx_valid = 1'b0;
        tx_voice_index = 8'h5A;
        tx_midi_note = 7'h7F;
        wait_dones(5);
        chk("b2b_edges", edges - e0, 80);
        repeat (20) @(negedge clk);
        chk("b2b_dones", dones, 5);
        chk("leftover_bytes", exp_b.size(), 0);
        chk("leftover_frames", exp_f.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
